// File: rtl/iobuf_turnaround_ctrl.sv
// Half-duplex sequencer for a bank of IOBUF-style pads: arbitrates TX/RX requesters,
// drives T/I, samples O and inserts hi-Z turnaround cycles on every direction change.
module iobuf_turnaround_ctrl #(
  parameter int WIDTH     = 8,
  parameter int TURN_CYC  = 2,
  parameter int MAX_BURST = 4
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             TX_REQ,
  input  logic [WIDTH-1:0] TX_DATA,
  output logic             TX_RDY,
  input  logic             RX_REQ,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  output logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] I,
  input  logic [WIDTH-1:0] O
);

  localparam int CNT_MAX = (TURN_CYC + 1 > MAX_BURST + 1) ? TURN_CYC + 1 : MAX_BURST + 1;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] TURN_LAST  = CW'(TURN_CYC - 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
  localparam logic [CW-1:0] BURST_SAT  = CW'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN_TX,
    S_DRIVE,
    S_TURN_RX,
    S_RECV
  } state_t;

  typedef enum logic {
    DIR_RX = 1'b0,
    DIR_TX = 1'b1
  } dir_t;

  state_t           state_q, state_d;
  dir_t             last_dir_q, last_dir_d;
  logic [CW-1:0]    turn_q, turn_d;
  logic [CW-1:0]    burst_q, burst_d;
  logic             hiz_q, hiz_d;
  logic [WIDTH-1:0] i_q, i_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;

  function automatic logic [CW-1:0] burst_sat_inc(input logic [CW-1:0] cnt);
    return (cnt >= BURST_SAT) ? cnt : cnt + CW'(1);
  endfunction

  // Next-state decode; burst/turn counters fall back to zero so every entry starts clean
  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    turn_d     = '0;
    burst_d    = '0;
    hiz_d      = 1'b1;
    i_d        = i_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (TX_REQ && RX_REQ) begin
          state_d = (last_dir_q == DIR_RX) ? S_TURN_TX : S_RECV;
        end else if (TX_REQ) begin
          state_d = S_TURN_TX;
        end else if (RX_REQ) begin
          state_d = S_RECV;
        end
      end

      S_TURN_TX: begin
        if (turn_q == TURN_LAST) begin
          state_d = S_DRIVE;
        end else begin
          turn_d = turn_q + CW'(1);
        end
      end

      S_DRIVE: begin
        last_dir_d = DIR_TX;
        if (!TX_REQ) begin
          state_d = S_TURN_RX;
        end else begin
          hiz_d   = 1'b0;
          i_d     = TX_DATA;
          burst_d = burst_sat_inc(burst_q);
          // The limit only matters when the receiver is actually waiting
          if (RX_REQ && (burst_q >= BURST_LAST)) begin
            state_d = S_TURN_RX;
          end
        end
      end

      S_TURN_RX: begin
        // A word accepted on the way out is still on the pad; that cycle is not hi-Z
        if (!hiz_q) begin
          turn_d = turn_q;
        end else if (turn_q == TURN_LAST) begin
          state_d = RX_REQ ? S_RECV : S_IDLE;
        end else begin
          turn_d = turn_q + CW'(1);
        end
      end

      S_RECV: begin
        last_dir_d = DIR_RX;
        if (!RX_REQ) begin
          state_d = TX_REQ ? S_TURN_TX : S_IDLE;
        end else begin
          rx_data_d  = O;
          rx_valid_d = 1'b1;
          burst_d    = burst_sat_inc(burst_q);
          if (TX_REQ && (burst_q >= BURST_LAST)) begin
            state_d = S_TURN_TX;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Register stage: all outputs come from here or from state_q
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_q    <= S_IDLE;
      last_dir_q <= DIR_RX;
      turn_q     <= '0;
      burst_q    <= '0;
      hiz_q      <= 1'b1;
      i_q        <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      turn_q     <= turn_d;
      burst_q    <= burst_d;
      hiz_q      <= hiz_d;
      i_q        <= i_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign TX_RDY   = (state_q == S_DRIVE);
  assign T        = {WIDTH{hiz_q}};
  assign I        = i_q;
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;

endmodule

// File: tb/tb_iobuf_turnaround_ctrl.sv
// Directed + random bench for iobuf_turnaround_ctrl; accepted TX words are queued and
// matched against I whenever the pad is driven.
module tb_iobuf_turnaround_ctrl;

  localparam int WIDTH     = 8;
  localparam int TURN_CYC  = 2;
  localparam int MAX_BURST = 4;

  logic             C = 1'b0;
  logic             CLR;
  logic             TX_REQ;
  logic [WIDTH-1:0] TX_DATA;
  logic             TX_RDY;
  logic             RX_REQ;
  logic [WIDTH-1:0] RX_DATA;
  logic             RX_VALID;
  logic [WIDTH-1:0] T;
  logic [WIDTH-1:0] I;
  logic [WIDTH-1:0] O;

  int n_cmp     = 0;
  int n_err     = 0;
  int cyc       = 0;
  int last_samp = -100;
  int drive_run = 0;
  int max_run   = 0;
  int n_drive   = 0;

  logic [WIDTH-1:0] txq[$];
  logic [WIDTH-1:0] o_pre;
  logic [WIDTH-1:0] t_pre;
  logic             rxreq_pre;
  logic             last_xfer = 1'b0;

  iobuf_turnaround_ctrl #(
    .WIDTH    (WIDTH),
    .TURN_CYC (TURN_CYC),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .C       (C),
    .CLR     (CLR),
    .TX_REQ  (TX_REQ),
    .TX_DATA (TX_DATA),
    .TX_RDY  (TX_RDY),
    .RX_REQ  (RX_REQ),
    .RX_DATA (RX_DATA),
    .RX_VALID(RX_VALID),
    .T       (T),
    .I       (I),
    .O       (O)
  );

  always #5 C = ~C;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: capture handshake/pad inputs before the edge, check outputs 1ns after it
  task automatic tick();
    logic             xfer;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] exp_i;
    xfer      = TX_REQ && TX_RDY;
    d         = TX_DATA;
    o_pre     = O;
    t_pre     = T;
    rxreq_pre = RX_REQ;
    @(posedge C);
    if (xfer && !CLR) txq.push_back(d);
    last_xfer = xfer;
    #1;
    cyc++;
    if (RX_VALID) begin
      last_samp = cyc - 1;
      chk("rx_data_sample", {24'd0, RX_DATA}, {24'd0, o_pre});
      chk("rx_valid_cause", {31'd0, rxreq_pre && (t_pre == {WIDTH{1'b1}})}, 32'd1);
    end
    if (T == '0) begin
      drive_run++;
      n_drive++;
      if (drive_run > max_run) max_run = drive_run;
      chk("turnaround_gap", {31'd0, (cyc - last_samp) > TURN_CYC}, 32'd1);
      chk("drive_has_word", {31'd0, txq.size() > 0}, 32'd1);
      if (txq.size() > 0) begin
        exp_i = txq.pop_front();
        chk("tx_drive_I", {24'd0, I}, {24'd0, exp_i});
      end
    end else begin
      drive_run = 0;
      chk("t_hiz_uniform", {24'd0, T}, {24'd0, {WIDTH{1'b1}}});
    end
  endtask

  initial begin
    logic [17:1] rdy_e;
    logic [17:1] drv_e;
    logic [17:1] rxv_e;
    logic        done;
    int          k;

    CLR     = 1'b1;
    TX_REQ  = 1'b0;
    RX_REQ  = 1'b0;
    TX_DATA = '0;
    O       = '0;

    // Reset state
    tick();
    tick();
    chk("rst_T", {24'd0, T}, 32'hFF);
    chk("rst_I", {24'd0, I}, 32'h00);
    chk("rst_TX_RDY", {31'd0, TX_RDY}, 32'd0);
    chk("rst_RX_VALID", {31'd0, RX_VALID}, 32'd0);
    chk("rst_RX_DATA", {24'd0, RX_DATA}, 32'h00);
    CLR = 1'b0;

    // Single TX word: cycle 0 IDLE, TURN_TX 1-2, DRIVE 3, pad driven 4, TURN_RX 5-6
    TX_REQ  = 1'b1;
    TX_DATA = 8'hA5;
    tick(); chk("single_c1_rdy", {31'd0, TX_RDY}, 32'd0);
    tick(); chk("single_c2_rdy", {31'd0, TX_RDY}, 32'd0);
    tick(); chk("single_c3_rdy", {31'd0, TX_RDY}, 32'd1);
            chk("single_c3_T", {24'd0, T}, 32'hFF);
    tick(); chk("single_c4_T", {24'd0, T}, 32'h00);
            chk("single_c4_I", {24'd0, I}, 32'hA5);
    TX_REQ = 1'b0;
    tick(); chk("single_c5_T", {24'd0, T}, 32'hFF);
            chk("single_c5_rdy", {31'd0, TX_RDY}, 32'd0);
    tick(); chk("single_c6_T", {24'd0, T}, 32'hFF);
    tick(); chk("single_c7_rdy", {31'd0, TX_RDY}, 32'd0);

    // RX sample from IDLE
    RX_REQ = 1'b1;
    tick(); chk("rx_c8_valid", {31'd0, RX_VALID}, 32'd0);
    O = 8'h3C;
    tick(); chk("rx_c9_valid", {31'd0, RX_VALID}, 32'd1);
            chk("rx_c9_data", {24'd0, RX_DATA}, 32'h3C);
    RX_REQ = 1'b0;
    tick(); chk("rx_c10_valid", {31'd0, RX_VALID}, 32'd0);
            chk("rx_c10_data", {24'd0, RX_DATA}, 32'h3C);

    // Fair sharing from IDLE with last direction RX
    rdy_e   = 17'b11_000000000_1111_00;
    drv_e   = 17'b1_000000000_1111_000;
    rxv_e   = 17'b000_1111_0000000000;
    TX_REQ  = 1'b1;
    RX_REQ  = 1'b1;
    TX_DATA = 8'h10;
    O       = 8'h80;
    for (int f = 1; f <= 17; f++) begin
      tick();
      chk($sformatf("fair_f%0d_rdy", f), {31'd0, TX_RDY}, {31'd0, rdy_e[f]});
      chk($sformatf("fair_f%0d_drive", f), {31'd0, T == '0}, {31'd0, drv_e[f]});
      chk($sformatf("fair_f%0d_rxv", f), {31'd0, RX_VALID}, {31'd0, rxv_e[f]});
      if (last_xfer) TX_DATA = TX_DATA + 8'd1;
      O = 8'h80 + WIDTH'(f);
    end
    TX_REQ = 1'b0;
    RX_REQ = 1'b0;
    repeat (4) tick();

    // Unopposed stream of 10 words: no hi-Z gap expected
    max_run   = 0;
    drive_run = 0;
    n_drive   = 0;
    done      = 1'b0;
    k         = 1;
    TX_REQ    = 1'b1;
    TX_DATA   = 8'h01;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (last_xfer) begin
        if (k == 10) begin
          TX_REQ = 1'b0;
          done   = 1'b1;
        end else begin
          k++;
          TX_DATA = WIDTH'(k);
        end
      end
    end
    chk("stream_completed", {31'd0, done}, 32'd1);
    repeat (4) tick();
    chk("stream_run_len", max_run, 32'd10);
    chk("stream_words", n_drive, 32'd10);
    chk("stream_queue_drained", txq.size(), 32'd0);

    // CLR in a driven DRIVE cycle: T must float before the next edge
    TX_REQ  = 1'b1;
    TX_DATA = 8'h5A;
    done    = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      tick();
      if (T == '0) done = 1'b1;
    end
    chk("clr_reached_drive", {31'd0, done}, 32'd1);
    #2;
    CLR = 1'b1;
    #1;
    chk("clr_async_T", {24'd0, T}, 32'hFF);
    chk("clr_async_TX_RDY", {31'd0, TX_RDY}, 32'd0);
    chk("clr_async_RX_VALID", {31'd0, RX_VALID}, 32'd0);
    chk("clr_async_RX_DATA", {24'd0, RX_DATA}, 32'h00);
    chk("clr_async_I", {24'd0, I}, 32'h00);
    txq.delete();
    TX_REQ = 1'b0;
    tick();
    CLR = 1'b0;
    tick();
    chk("clr_idle_rdy", {31'd0, TX_RDY}, 32'd0);

    // After reset both requesters together must go TX first
    TX_REQ  = 1'b1;
    RX_REQ  = 1'b1;
    TX_DATA = 8'hC3;
    tick(); chk("post_clr_c1_rdy", {31'd0, TX_RDY}, 32'd0);
    tick(); chk("post_clr_c2_rdy", {31'd0, TX_RDY}, 32'd0);
    tick(); chk("post_clr_c3_rdy", {31'd0, TX_RDY}, 32'd1);

    // Random request traffic; invariants and scoreboard run inside tick()
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 7) == 0) RX_REQ = 1'($urandom_range(0, 1));
      if (last_xfer || !TX_REQ) TX_DATA = WIDTH'($urandom);
      if ($urandom_range(0, 7) == 0) TX_REQ = 1'($urandom_range(0, 1));
      O = WIDTH'($urandom);
      tick();
    end
    TX_REQ = 1'b0;
    RX_REQ = 1'b0;
    repeat (8) tick();
    chk("random_queue_drained", txq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
